// File: rtl/cskip_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cskip_pkg
//  Purpose  : Shared types and sizing helpers for the sequential carry-skip
//             subtractor (state encoding, group count, top-group width,
//             skip-counter width).
//  Revision : 1.0 - initial release
// ============================================================================
package cskip_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of GROUP-bit slices needed to cover WIDTH bits.
  function automatic int f_ngroups(input int width, input int group);
    return (width + group - 1) / group;
  endfunction

  // Bits actually populated in the most significant group.
  function automatic int f_top_width(input int width, input int group);
    return width - (f_ngroups(width, group) - 1) * group;
  endfunction

  // Skip counter must be able to hold the value NGROUPS.
  function automatic int f_skips_w(input int width, input int group);
    return $clog2(f_ngroups(width, group) + 1);
  endfunction

  localparam int c_SKIPS_W = f_skips_w(41, 4);

endpackage
`default_nettype wire

// File: rtl/cskip_sub_grp.sv
`default_nettype none
// ============================================================================
//  Module   : cskip_sub_grp
//  Purpose  : Combinational GROUP-bit carry-skip slice. Adds a_g + nb_g + cin
//             over the bits enabled in valid_mask and bypasses the ripple
//             carry when every valid bit propagates.
//  Ports    : i_a_g, i_nb_g  - slice operands (nb is already inverted)
//             i_cin          - carry into the slice
//             i_valid_mask   - 1 for populated bits, 0 for pad bits
//             o_s_g          - slice sum (pad bits forced to 0)
//             o_cout         - slice carry out
//             o_skip         - propagate was all-ones on the valid bits
//  Revision : 1.0 - initial release
// ============================================================================
module cskip_sub_grp #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_a_g,
  input  logic [GROUP-1:0] i_nb_g,
  input  logic             i_cin,
  input  logic [GROUP-1:0] i_valid_mask,
  output logic [GROUP-1:0] o_s_g,
  output logic             o_cout,
  output logic             o_skip
);

  logic [GROUP-1:0] w_hsum;
  logic [GROUP-1:0] w_prop;
  logic [GROUP-1:0] w_gen;
  logic [GROUP:0]   w_c;

  always_comb begin
    w_hsum = i_a_g ^ i_nb_g;
    // Pad bits act as pure propagate so the ripple carry passes straight
    // through them and the all-ones check only sees populated bits.
    w_prop = w_hsum | ~i_valid_mask;
    w_gen  = i_a_g & i_nb_g & i_valid_mask;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < GROUP; i++) begin
      w_c[i+1] = w_gen[i] | (w_prop[i] & w_c[i]);
    end
    o_s_g  = (w_hsum ^ w_c[GROUP-1:0]) & i_valid_mask;
    o_skip = &w_prop;
    o_cout = o_skip ? i_cin : w_c[GROUP];
  end

endmodule
`default_nettype wire

// File: rtl/cskip_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cskip_sub_seq
//  Purpose  : Multi-cycle unsigned subtractor a - b = a + ~b + 1, one
//             carry-skip group per clock, with valid/ready on both sides.
//  Ports    : i_clk, i_rst          - clock, synchronous active-high reset
//             i_valid / o_ready     - operand handshake
//             i_sub_term1/2         - minuend a / subtrahend b
//             o_valid / i_ready     - result handshake
//             o_diff                - (a - b) mod 2^WIDTH
//             o_borrow              - a < b
//             o_skips               - groups whose carry was skipped
//  Revision : 1.0 - initial release
// ============================================================================
module cskip_sub_seq
  import cskip_pkg::*;
#(
  parameter int WIDTH = 41,
  parameter int GROUP = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [WIDTH-1:0]                   i_sub_term1,
  input  logic [WIDTH-1:0]                   i_sub_term2,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [WIDTH-1:0]                   o_diff,
  output logic                               o_borrow,
  output logic [f_skips_w(WIDTH, GROUP)-1:0] o_skips
);

  localparam int c_NGROUPS = f_ngroups(WIDTH, GROUP);
  localparam int c_TOP_W   = f_top_width(WIDTH, GROUP);
  localparam int c_SW      = f_skips_w(WIDTH, GROUP);
  localparam int c_GRP_W   = (c_NGROUPS > 1) ? $clog2(c_NGROUPS) : 1;
  localparam int c_PAD_W   = c_NGROUPS * GROUP;
  localparam logic [GROUP-1:0]   c_TOP_MASK = {GROUP{1'b1}} >> (GROUP - c_TOP_W);
  localparam logic [c_GRP_W-1:0] c_LAST_GRP = c_GRP_W'(c_NGROUPS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_nb;
  logic                 r_carry;
  logic [c_GRP_W-1:0]   r_grp;
  logic [WIDTH-1:0]     r_diff;
  logic                 r_borrow;
  logic [c_SW-1:0]      r_skips;

  logic                 w_accept;
  logic                 w_step;
  logic                 w_last;
  logic [c_PAD_W-1:0]   w_a_pad;
  logic [c_PAD_W-1:0]   w_nb_pad;
  logic [GROUP-1:0]     w_a_g;
  logic [GROUP-1:0]     w_nb_g;
  logic [GROUP-1:0]     w_mask;
  logic [GROUP-1:0]     w_s_g;
  logic                 w_cout;
  logic                 w_skip;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_valid) w_state_nxt = RUN;
      RUN:     if (w_last)  w_state_nxt = DONE;
      DONE:    if (i_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (decoded from the state register only) ----
  always_comb begin
    o_ready  = (r_state == IDLE);
    o_valid  = (r_state == DONE);
    w_accept = (r_state == IDLE) && i_valid;
    w_step   = (r_state == RUN);
    w_last   = (r_grp == c_LAST_GRP);
  end

  // ---------------- Operand mux for the shared slice ----------------
  assign w_a_pad  = c_PAD_W'(r_a);
  assign w_nb_pad = c_PAD_W'(r_nb);

  always_comb begin
    w_a_g  = '0;
    w_nb_g = '0;
    for (int g = 0; g < c_NGROUPS; g++) begin
      if (r_grp == c_GRP_W'(g)) begin
        w_a_g  = w_a_pad[g*GROUP +: GROUP];
        w_nb_g = w_nb_pad[g*GROUP +: GROUP];
      end
    end
    w_mask = w_last ? c_TOP_MASK : {GROUP{1'b1}};
  end

  cskip_sub_grp #(
    .GROUP (GROUP)
  ) u_grp (
    .i_a_g        (w_a_g),
    .i_nb_g       (w_nb_g),
    .i_cin        (r_carry),
    .i_valid_mask (w_mask),
    .o_s_g        (w_s_g),
    .o_cout       (w_cout),
    .o_skip       (w_skip)
  );

  // ---------------- Datapath registers ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_nb     <= '0;
      r_carry  <= 1'b0;
      r_grp    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_skips  <= '0;
    end else if (w_accept) begin
      r_a     <= i_sub_term1;
      r_nb    <= ~i_sub_term2;
      r_carry <= 1'b1;           // the +1 of the two's-complement negation
      r_grp   <= '0;
      r_diff  <= '0;
      r_skips <= '0;
    end else if (w_step) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_grp == c_GRP_W'(i / GROUP)) r_diff[i] <= w_s_g[i % GROUP];
      end
      r_carry <= w_cout;
      r_grp   <= r_grp + 1'b1;
      r_skips <= r_skips + c_SW'(w_skip);
      if (w_last) r_borrow <= ~w_cout;
    end
  end

  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;
  assign o_skips  = r_skips;

endmodule
`default_nettype wire

// File: doc/cskip_sub_seq.md
# cskip_sub_seq

Multi-cycle unsigned subtractor built from carry-skip group slices, the counterpart to the team's combinational carry-skip adders. It computes `a - b` as `a + ~b + 1`, processing one GROUP-bit slice per clock, and reports the difference, the borrow-out and the count of groups whose carry was skipped. It sits behind a valid/ready handshake on both sides, so it drops into the adder-classification datapath wherever area matters more than latency.

## Interface
- `WIDTH`, 41, operand and difference width.
- `GROUP`, 4, bits per skip group; the top group holds `WIDTH - (NGROUPS-1)*GROUP` bits (1 at defaults).
- `i_clk` in 1: single clock; all state updates on the rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_valid` in 1: operands valid.
- `o_ready` out 1: block can accept operands.
- `i_sub_term1` in WIDTH: minuend `a`.
- `i_sub_term2` in WIDTH: subtrahend `b`.
- `o_valid` out 1: result valid.
- `i_ready` in 1: downstream accepts result.
- `o_diff` out WIDTH: `(a - b) mod 2^WIDTH`.
- `o_borrow` out 1: 1 iff `a < b` (unsigned); equals the inverted final carry.
- `o_skips` out `$clog2(NGROUPS+1)` (4 at defaults): number of groups whose propagate was all-ones.

## Operation
- `NGROUPS = ceil(WIDTH/GROUP)`, which is 11 at defaults.
- FSM states:
  - IDLE: `o_ready=1`. When `i_valid && o_ready`:
    - latch `a` and `~b`;
    - `carry <= 1`, `grp <= 0`, `o_skips <= 0`, `o_diff <= 0`;
    - go to RUN.
  - RUN: each cycle processes group `grp`:
    - `p = a_g ^ ~b_g`, ripple the sum within the group;
    - group carry-out = carry-in when `p` is all-ones on the valid bits (skip; `o_skips` increments), otherwise the ripple carry-out;
    - write the sum bits into `o_diff[grp]`, update `carry`, increment `grp`;
    - at `grp == NGROUPS-1`: `o_borrow <= ~carry_out`, go to DONE.
  - DONE: `o_valid=1`; `o_diff`, `o_borrow` and `o_skips` are held stable. When `i_ready` is high, go to IDLE.
- Partial top group: pad bits are excluded from the propagate check and the sum.
- `i_valid` outside IDLE is ignored. Operand inputs are sampled only on the accept edge; changes afterwards have no effect.
- Reset values: `o_valid=0`, `o_ready=1`, `o_diff=0`, `o_borrow=0`, `o_skips=0`, state IDLE.
- Reset in any state, including mid-RUN or DONE: the next cycle is IDLE with the reset values above, and no result is emitted.
- A reset cycle coinciding with `i_valid` does not accept the operands.
- `o_skips` saturates naturally, since its width holds NGROUPS.

## Timing
- Accept edge = `i_valid && o_ready` at edge T.
- `o_valid` rises after edge T+NGROUPS (T+11), giving a latency of NGROUPS cycles.
- The result is held as long as `i_ready` is low (back-pressure).
- Handshake at edge U (`o_valid && i_ready`) → `o_valid=0` and `o_ready=1` after U. The next accept can occur at edge U+1 at the earliest.
- Peak throughput is one operation per NGROUPS+2 cycles.
- No combinational path from `i_valid` to `o_ready` or from `i_ready` to `o_valid`; all outputs are registered.

## Structure
- Package `cskip_pkg`:
  - state enum {IDLE, RUN, DONE};
  - functions for `NGROUPS` and top-group width;
  - `o_skips` width constant.
- Sub-module `cskip_sub_grp`: combinational GROUP-bit slice.
  - Inputs: `a_g`, `nb_g`, `cin`, `valid_mask`.
  - Outputs: `s_g`, `cout`, `skip`.
  - One instance, reused each cycle through a `grp`-indexed operand mux.
- The top level holds the FSM, group counter, carry register and result registers.

## Test plan
- Reset: assert `i_rst` 2 cycles → `o_valid=0`, `o_ready=1`, `o_diff=0`, `o_borrow=0`, `o_skips=0`.
- a=100, b=58, `i_ready=1` → `o_diff=42`, `o_borrow=0`, `o_valid` high exactly 11 cycles after accept and for 1 cycle; `o_ready` high the following cycle.
- a=0, b=1 → `o_diff=0x1FF_FFFF_FFFF`, `o_borrow=1`, `o_skips=10`.
- a=b=0x155_5555_5555 → `o_diff=0`, `o_borrow=0`, `o_skips=11`.
- Back-pressure: hold `i_ready=0` for 5 cycles after `o_valid`; pulse `i_valid` with new operands → outputs stable, `o_ready=0`, new operands ignored; raise `i_ready` → IDLE next cycle.
- Assert `i_rst` in the 5th RUN cycle of a=7, b=3 → next cycle IDLE with reset values; no `o_valid` pulse; a following a=7, b=3 → `o_diff=4`.
